// File: rtl/regfile_mp_pkg.sv
// rtl/regfile_mp_pkg.sv - shared FSM encoding and default widths for the multi-port register file
package regfile_mp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int DEF_NRD    = 2;
  localparam int DEF_BYPASS = 1;

endpackage

// File: rtl/regfile_rdport.sv
// rtl/regfile_rdport.sv - one combinational read port: entry mux, write forwarding, pending lookup
module regfile_rdport #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int BYPASS = 1
) (
  input  logic [DATA_W-1:0]      regs [2**ADDR_W],
  input  logic [2**ADDR_W-1:0]   pend,
  input  logic [ADDR_W-1:0]      rdAddr,
  input  logic                   fwdEn,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdData,
  output logic                   rdPend
);

  always_comb begin
    rdData = regs[rdAddr];
    if (rdAddr == '0) begin
      rdData = '0;
    end else if ((BYPASS != 0) && fwdEn && (waddr == rdAddr)) begin
      rdData = wdata;
    end
  end

  // Pending status reflects the stored scoreboard only; a same-cycle write does not clear it early.
  assign rdPend = pend[rdAddr];

endmodule

// File: rtl/regfile_mp.sv
// rtl/regfile_mp.sv - multi-read-port register file with pending scoreboard and sequential soft clear
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int NRD    = DEF_NRD,
  parameter int BYPASS = DEF_BYPASS
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_pend,
  input  logic                    we,
  input  logic [ADDR_W-1:0]       waddr,
  input  logic [DATA_W-1:0]       wdata,
  input  logic                    set_pend,
  input  logic [ADDR_W-1:0]       pend_addr,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  state_t            state;
  logic [ADDR_W-1:0] idx;
  logic              busyReg;
  logic              doneReg;
  logic              writeOk;
  logic              pendOk;

  assign writeOk = (state == IDLE) && we && (waddr != '0);
  assign pendOk  = (state == IDLE) && set_pend && (pend_addr != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend    <= '0;
      state   <= IDLE;
      idx     <= '0;
      busyReg <= 1'b0;
      doneReg <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (writeOk) begin
            regs[waddr] <= wdata;
            pend[waddr] <= 1'b0;
          end
          // Issued after the write clear so a same-index set_pend ends up set.
          if (pendOk) begin
            pend[pend_addr] <= 1'b1;
          end
          if (clr_req) begin
            state   <= CLEAR;
            idx     <= ADDR_W'(1);
            busyReg <= 1'b1;
          end
        end
        CLEAR: begin
          regs[idx] <= '0;
          pend[idx] <= 1'b0;
          if (idx == '1) begin
            state   <= DONE;
            doneReg <= 1'b1;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        DONE: begin
          state   <= IDLE;
          busyReg <= 1'b0;
          doneReg <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          busyReg <= 1'b0;
          doneReg <= 1'b0;
        end
      endcase
    end
  end

  assign clr_busy = busyReg;
  assign clr_done = doneReg;

  genvar k;
  generate
    for (k = 0; k < NRD; k++) begin : gRd
      regfile_rdport #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
      ) uRdPort (
        .regs   (regs),
        .pend   (pend),
        .rdAddr (rd_addr[k*ADDR_W +: ADDR_W]),
        .fwdEn  (writeOk),
        .waddr  (waddr),
        .wdata  (wdata),
        .rdData (rd_data[k*DATA_W +: DATA_W]),
        .rdPend (rd_pend[k])
      );
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb/tb_regfile_mp.sv - directed and randomized bench for regfile_mp against a behavioural model
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rdData, rdDataNb;
  logic [NR-1:0] rdPend, rdPendNb;
  logic we, set_pend, clr_req;
  logic [AW-1:0] waddr, pend_addr;
  logic [DW-1:0] wdata;
  logic clrBusy, clrDone, clrBusyNb, clrDoneNb;

  logic [11:0] sRdAddr;
  logic [63:0] sRdData;
  logic [3:0]  sRdPend;
  logic sWe, sSetPend, sClrReq, sBusy, sDone;
  logic [2:0]  sWaddr, sPendAddr;
  logic [15:0] sWdata;

  regfile_mp dut (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rdData), .rd_pend(rdPend),
    .we(we), .waddr(waddr), .wdata(wdata), .set_pend(set_pend), .pend_addr(pend_addr),
    .clr_req(clr_req), .clr_busy(clrBusy), .clr_done(clrDone)
  );

  regfile_mp #(.BYPASS(0)) dutNb (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rdDataNb), .rd_pend(rdPendNb),
    .we(we), .waddr(waddr), .wdata(wdata), .set_pend(set_pend), .pend_addr(pend_addr),
    .clr_req(clr_req), .clr_busy(clrBusyNb), .clr_done(clrDoneNb)
  );

  regfile_mp #(.DATA_W(16), .ADDR_W(3), .NRD(4), .BYPASS(1)) dutSmall (
    .clk(clk), .reset(reset), .rd_addr(sRdAddr), .rd_data(sRdData), .rd_pend(sRdPend),
    .we(sWe), .waddr(sWaddr), .wdata(sWdata), .set_pend(sSetPend), .pend_addr(sPendAddr),
    .clr_req(sClrReq), .clr_busy(sBusy), .clr_done(sDone)
  );

  logic [31:0] mMem [DEPTH];
  bit          mPend [DEPTH];
  int          mClr;
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < DEPTH; i++) begin
      mMem[i] = '0;
      mPend[i] = 1'b0;
    end
    mClr = 0;
  endtask

  function automatic logic [31:0] expRd(input logic [4:0] a, input bit byp);
    if (a == 0) return 32'h0;
    if (byp && we && waddr == a && mClr == 0) return wdata;
    return mMem[a];
  endfunction

  task automatic checkOutputs();
    logic [4:0] a;
    for (int k = 0; k < NR; k++) begin
      a = rd_addr[k*AW +: AW];
      chk($sformatf("rd_data[%0d] a=%0d", k, a), rdData[k*DW +: DW], expRd(a, 1'b1));
      chk($sformatf("nb rd_data[%0d] a=%0d", k, a), rdDataNb[k*DW +: DW], expRd(a, 1'b0));
      chk($sformatf("rd_pend[%0d] a=%0d", k, a), {31'b0, rdPend[k]}, {31'b0, mPend[a]});
      chk($sformatf("nb rd_pend[%0d] a=%0d", k, a), {31'b0, rdPendNb[k]}, {31'b0, mPend[a]});
    end
    chk("clr_busy", {31'b0, clrBusy}, {31'b0, mClr != 0});
    chk("clr_done", {31'b0, clrDone}, {31'b0, mClr == DEPTH});
    chk("nb clr_busy", {31'b0, clrBusyNb}, {31'b0, mClr != 0});
    chk("nb clr_done", {31'b0, clrDoneNb}, {31'b0, mClr == DEPTH});
  endtask

  // Model advance at a rising edge: busy cycle c < DEPTH zeroes entry c; cycle DEPTH is the done cycle.
  task automatic modelEdge();
    if (mClr == 0) begin
      if (we && waddr != 0) begin
        mMem[waddr] = wdata;
        mPend[waddr] = 1'b0;
      end
      if (set_pend && pend_addr != 0) mPend[pend_addr] = 1'b1;
      if (clr_req) mClr = 1;
    end else if (mClr < DEPTH) begin
      mMem[mClr] = '0;
      mPend[mClr] = 1'b0;
      mClr++;
    end else begin
      mClr = 0;
    end
  endtask

  task automatic step();
    @(negedge clk);
    checkOutputs();
    @(posedge clk);
    modelEdge();
    #1;
  endtask

  task automatic idle();
    we = 1'b0; set_pend = 1'b0; clr_req = 1'b0;
  endtask

  initial begin
    int busyCnt, doneAt;
    reset = 1'b0;
    rd_addr = '0; we = 0; waddr = '0; wdata = '0; set_pend = 0; pend_addr = '0; clr_req = 0;
    sRdAddr = '0; sWe = 0; sWaddr = '0; sWdata = '0; sSetPend = 0; sPendAddr = '0; sClrReq = 0;
    modelReset();
    #12;
    checkOutputs();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // write r5, same-cycle bypass vs. old value, then registered read
    we = 1; waddr = 5; wdata = 32'hDEADBEEF; rd_addr = {5'd5, 5'd5};
    #1;
    chk("bypass r5", rdData[31:0], 32'hDEADBEEF);
    chk("no-bypass r5", rdDataNb[31:0], 32'h0);
    step();
    idle();
    #1;
    chk("r5 port0", rdData[31:0], 32'hDEADBEEF);
    chk("r5 port1", rdData[63:32], 32'hDEADBEEF);
    chk("nb r5 port1", rdDataNb[63:32], 32'hDEADBEEF);
    step();

    // r0 is immune to writes and set_pend
    we = 1; waddr = 0; wdata = 32'h1234; set_pend = 1; pend_addr = 0; rd_addr = {5'd0, 5'd0};
    step();
    idle();
    #1;
    chk("r0 data", rdData[31:0], 32'h0);
    chk("r0 pend", {31'b0, rdPend[0]}, 32'h0);
    step();

    // pend on r7 held until its write edge; same-cycle set+write on r9 leaves pend set
    set_pend = 1; pend_addr = 7; rd_addr = {5'd7, 5'd7};
    step();
    idle();
    step();
    we = 1; waddr = 7; wdata = 32'h77;
    #1;
    chk("r7 pend before write edge", {31'b0, rdPend[0]}, 32'h1);
    step();
    idle();
    #1;
    chk("r7 pend after write", {31'b0, rdPend[0]}, 32'h0);
    we = 1; waddr = 9; wdata = 32'h99; set_pend = 1; pend_addr = 9; rd_addr = {5'd9, 5'd9};
    step();
    idle();
    #1;
    chk("r9 data", rdData[31:0], 32'h99);
    chk("r9 pend", {31'b0, rdPend[1]}, 32'h1);
    step();

    // fill, then clear with a simultaneous write; writes during the clear are dropped
    for (int i = 1; i < DEPTH; i++) begin
      we = 1; waddr = AW'(i); wdata = i; rd_addr = {AW'(i), AW'(DEPTH - i)};
      step();
    end
    we = 1; waddr = 3; wdata = 32'hAA; clr_req = 1;
    step();
    busyCnt = 0; doneAt = 0;
    for (int c = 1; c <= 34; c++) begin
      if (clrBusy) busyCnt++;
      if (clrDone) doneAt = busyCnt;
      idle();
      if (mClr != 0) begin
        we = 1; waddr = AW'($urandom_range(1, DEPTH - 1)); wdata = $urandom;
        set_pend = 1; pend_addr = AW'($urandom_range(1, DEPTH - 1)); clr_req = 1;
      end
      rd_addr = {AW'($urandom), AW'($urandom)};
      step();
    end
    chk("clear busy cycles", busyCnt, 32);
    chk("clear done cycle", doneAt, 32);
    idle();
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr = {AW'(a), AW'(a)};
      #1;
      chk($sformatf("cleared r%0d", a), rdData[31:0], 32'h0);
      step();
    end

    // reset in the middle of a clear aborts it with no done pulse
    for (int i = 1; i < DEPTH; i++) begin
      we = 1; waddr = AW'(i); wdata = 32'h100 + i;
      step();
    end
    idle();
    clr_req = 1;
    step();
    idle();
    for (int c = 0; c < 10; c++) step();
    rd_addr = {5'd20, 5'd25};
    #2;
    reset = 1'b0;
    #1;
    chk("mid-clear reset busy", {31'b0, clrBusy}, 32'h0);
    chk("mid-clear reset done", {31'b0, clrDone}, 32'h0);
    chk("mid-clear reset r20", rdData[63:32], 32'h0);
    chk("mid-clear reset r25", rdData[31:0], 32'h0);
    modelReset();
    @(posedge clk); #1;
    reset = 1'b1;
    for (int c = 0; c < 35; c++) begin
      rd_addr = {AW'($urandom), AW'($urandom)};
      step();
    end

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      we = 1'($urandom); waddr = AW'($urandom); wdata = $urandom;
      set_pend = ($urandom_range(0, 3) == 0); pend_addr = AW'($urandom);
      clr_req = ($urandom_range(0, 59) == 0);
      rd_addr = {AW'($urandom), AW'($urandom)};
      if ($urandom_range(0, 3) == 0) rd_addr[AW-1:0] = waddr;
      step();
    end
    idle();

    // narrow four-port configuration
    for (int i = 1; i < 8; i++) begin
      sWe = 1; sWaddr = 3'(i); sWdata = 16'(i * 16'h111);
      @(posedge clk); #1;
    end
    sWe = 0;
    sRdAddr = {3'd4, 3'd3, 3'd2, 3'd1};
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("small port%0d r%0d", k, k + 1), {16'h0, sRdData[k*16 +: 16]}, (k + 1) * 32'h111);
    sRdAddr = {3'd0, 3'd5, 3'd6, 3'd7};
    #1;
    chk("small port0 r7", {16'h0, sRdData[15:0]}, 32'h777);
    chk("small port1 r6", {16'h0, sRdData[31:16]}, 32'h666);
    chk("small port2 r5", {16'h0, sRdData[47:32]}, 32'h555);
    chk("small port3 r0", {16'h0, sRdData[63:48]}, 32'h0);
    sClrReq = 1;
    @(posedge clk); #1;
    sClrReq = 0;
    busyCnt = 0; doneAt = 0;
    for (int c = 0; c < 20; c++) begin
      if (sBusy) busyCnt++;
      if (sDone) doneAt = busyCnt;
      @(posedge clk); #1;
    end
    chk("small clear busy cycles", busyCnt, 8);
    chk("small clear done cycle", doneAt, 8);
    for (int k = 0; k < 4; k++)
      chk($sformatf("small cleared port%0d", k), {16'h0, sRdData[k*16 +: 16]}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, data word width in bits.
REQ-002 SHALL provide parameter ADDR_W, default 5, register index width; DEPTH = 2**ADDR_W entries.
REQ-003 SHALL provide parameter NRD, default 2, number of independent read ports (1..4).
REQ-004 SHALL provide parameter BYPASS, default 1, which enables write-to-read forwarding when 1.
REQ-005 SHALL provide port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-006 SHALL provide port reset, input, 1 bit, asynchronous active-low reset; 0 resets, 1 runs.
REQ-007 SHALL provide port rd_addr, input, NRD*ADDR_W bits, read indices; port k occupies slice k.
REQ-008 SHALL provide port rd_data, output, NRD*DATA_W bits, read data per port.
REQ-009 SHALL provide port rd_pend, output, NRD bits, which flags the scoreboard pending bit of each read index.
REQ-010 SHALL provide port we, input, 1 bit, write enable.
REQ-011 SHALL provide port waddr, input, ADDR_W bits, write index.
REQ-012 SHALL provide port wdata, input, DATA_W bits, write data.
REQ-013 SHALL provide port set_pend, input, 1 bit, which marks a destination as pending (long-latency op issued).
REQ-014 SHALL provide port pend_addr, input, ADDR_W bits, the index to mark pending.
REQ-015 SHALL provide port clr_req, input, 1 bit, which requests a sequential soft clear.
REQ-016 SHALL provide port clr_busy, output, 1 bit, high while the soft clear is in progress.
REQ-017 SHALL provide port clr_done, output, 1 bit, a one-cycle pulse when the soft clear completes.

Function
REQ-018 Entry 0 SHALL always read as 0; writes and set_pend to index 0 SHALL be ignored.
REQ-019 Reads SHALL be combinational: rd_data[k] = entry[rd_addr[k]] with zero latency.
REQ-020 With BYPASS=1, we=1, waddr=rd_addr[k]!=0 and FSM in IDLE, rd_data[k] SHALL equal wdata in the same cycle; with BYPASS=0, rd_data[k] SHALL return the old value.
REQ-021 With we=1, waddr!=0 and FSM in IDLE, the write SHALL update the entry on the rising edge and clear pend[waddr].
REQ-022 set_pend=1, pend_addr!=0, FSM in IDLE SHALL set pend[pend_addr] on the rising edge.
REQ-023 When we and set_pend target the same index in one cycle, the data SHALL be written and pend SHALL end set (set wins).
REQ-024 rd_pend[k] SHALL be combinational pend[rd_addr[k]] and SHALL NOT be bypassed by a same-cycle write.
REQ-025 The FSM SHALL have states IDLE, CLEAR, DONE.
REQ-026 IDLE -> CLEAR SHALL occur on clr_req=1; the index counter SHALL load 1.
REQ-027 In CLEAR, each cycle SHALL zero entry[idx] and pend[idx], then increment idx.
REQ-028 The FSM SHALL go CLEAR -> DONE after idx=DEPTH-1 is cleared, giving DEPTH-1 cycles in CLEAR.
REQ-029 DONE -> IDLE SHALL be unconditional after one cycle; clr_done=1 only in DONE.
REQ-030 clr_busy SHALL equal 1 in CLEAR and DONE.
REQ-031 While clr_busy=1, we, set_pend and clr_req SHALL be ignored (dropped, not queued); reads SHALL return the current array contents.
REQ-032 A clr_req and a we in the same IDLE cycle SHALL perform the write, then begin the clear.
REQ-033 The idx counter SHALL be ADDR_W bits wide with no wrap past DEPTH-1.

Reset
REQ-034 reset=0 SHALL asynchronously zero all entries and all pend bits, force the FSM to IDLE and idx to 0, and drive clr_busy=0 and clr_done=0.
REQ-035 Reset asserted mid-CLEAR SHALL abort the clear immediately; no clr_done pulse SHALL be produced.
REQ-036 Release SHALL take effect at the first rising clk edge with reset=1.

Structure
REQ-037 A shared package SHALL hold the FSM state encoding (IDLE=2'd0, CLEAR=2'd1, DONE=2'd2) and the default width constants.
REQ-038 The block SHALL contain one sub-module, regfile_rdport (mux plus bypass plus pend lookup), instantiated NRD times via generate.

Verification
REQ-039 Scenario: write 0xDEADBEEF to r5, then read r5 on both ports the next cycle -> 0xDEADBEEF; same-cycle read with BYPASS=1 -> 0xDEADBEEF; with BYPASS=0 -> 0.
REQ-040 Scenario: write 0x1234 to r0 -> r0 reads 0; set_pend r0 -> rd_pend stays 0.
REQ-041 Scenario: set_pend r7, then write r7 two cycles later -> rd_pend=1 until the write edge, then 0; same-cycle set_pend+write on r9 -> data written, pend=1.
REQ-042 Scenario: fill r1..r31 with index values, pulse clr_req -> clr_busy high for 32 cycles, clr_done on cycle 32, all reads 0, and a we issued during the clear is lost.
REQ-043 Scenario: assert reset=0 at clear cycle 10 -> clr_busy=0 immediately, all entries 0, no clr_done.
REQ-044 Scenario: NRD=4, DATA_W=16, ADDR_W=3 -> four ports read distinct entries correctly; the clear lasts 7 cycles plus DONE.
